interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Consumes the `line` outputs of one or more `timer` instances, plus other peripheral event lines.
- Captures rising edges into pending flags, applies a software-written enable mask and selects the highest-priority enabled request.
- Presents the request to the Forth CPU core as a single `irq` with a vector number.
- Runs an ack/done handshake so that only one interrupt is in service at a time.

Parameters:
- SOURCES, 8, number of interrupt source inputs (1..2**VECTOR_BITS).
- VECTOR_BITS, 3, width of the vector number output.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset: when reset==0 at a rising clock edge, all state is cleared.
- sources  input  SOURCES  event lines (e.g. timer `line`); a rising edge raises the request.
- mask_wr  input  1  when 1, load `mask_data` into the enable mask.
- mask_data  input  SOURCES  new mask value; bit i=1 enables source i.
- irq_ack  input  1  CPU accepts the presented vector.
- irq_done  input  1  CPU has finished its handler.
- irq  output  1  interrupt request to the CPU.
- irq_vector  output  VECTOR_BITS  index of the requested or in-service source.
- pending  output  SOURCES  raw pending flags (status, unmasked).
- busy  output  1  1 while in the SERVICE state.

Behaviour:
- Reset (reset==0 at an edge):
  - src_prev=0, pending=0, mask=0 (all disabled), state=IDLE.
  - irq=0, irq_vector=0, busy=0.
  - Reset has priority over every other input and aborts any in-progress request or service.
- Edge detect: edge[i] = sources[i] & ~src_prev[i]. src_prev <= sources every non-reset edge.
  - Because src_prev resets to 0, a source already high when reset releases counts as an edge on the first active clock.
  - A level held high raises exactly one request.
- Pending:
  - pending[i] is set on the edge where edge[i]=1. It is set regardless of mask; masked requests are held, not lost.
  - It is cleared only by acceptance (see REQ) or by reset.
  - If a set and a clear for the same bit occur in one cycle, the set wins and the bit stays 1.
- Mask:
  - When mask_wr=1, mask <= mask_data at the edge, effective for selection in the next cycle.
  - Unmasking an already-pending source raises its request.
- Selection: active = pending & mask. The winner is the lowest index i with active[i]=1 (index 0 has highest priority).
- State machine:
  - IDLE: irq=0, busy=0. If active!=0: irq_vector <= winner, irq <= 1, go to REQ. A source edge therefore gives irq=1 two clock edges after the source rises: pending at edge 1, irq at edge 2.
  - REQ: irq=1, irq_vector held stable.
    - Masking or a new higher-priority pending source does not change the vector or withdraw irq.
    - If irq_ack=1: pending[irq_vector] <= 0, irq <= 0, busy <= 1, go to SERVICE.
  - SERVICE: irq=0, busy=1, irq_vector still holds the in-service index. No new request is presented (no nesting).
    - If irq_done=1: busy <= 0, go to IDLE.
    - If active!=0 in the IDLE cycle that follows, the next request is presented one edge later.
- Handshake errors:
  - irq_ack outside REQ is ignored.
  - irq_done outside SERVICE is ignored.
  - irq_ack and irq_done high together in REQ: only the ack takes effect.
- A repeat edge on the in-service source during SERVICE sets its pending bit again. It is served after done.

Test Plan:
- Reset then mask: hold reset=0 for 2 clocks with sources=8'hFF → all outputs 0. Release reset with sources=8'hFF → pending=8'hFF one edge later. irq stays 0 because mask=0. Write mask_data=8'h10 → irq=1 with irq_vector=4 on the following edge.
- Basic flow: mask=8'hFF, sources[2] rises → pending=8'h04 after 1 edge, irq=1 and vector=2 after 2 edges. Pulse irq_ack → pending=0, irq=0, busy=1. Pulse irq_done → busy=0, state IDLE.
- Priority: sources[5] and sources[1] rise in the same cycle → vector=1. After ack+done → vector=5 presented. Pending returns to 0 after the second ack.
- Level hold: a timer line held high for 100 cycles → exactly one request. A second rise after a low cycle → a new request.
- Set/clear collision: in REQ with vector=3, sources[3] rises in the same cycle as irq_ack → pending[3] remains 1 and is re-presented after done.
- Mid-operation reset: reset=0 during SERVICE with pending=8'h22 → on the next edge pending=0, busy=0, irq=0, mask=0. A later irq_done is ignored.

Source files
------------

// File: rtl/interrupt_controller.sv
// Interrupt controller: rising-edge capture into pending flags, enable mask,
// fixed priority (index 0 highest) and a single-in-service ack/done handshake.
module interrupt_controller #(
  parameter int unsigned SOURCES     = 8,
  parameter int unsigned VECTOR_BITS = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SOURCES-1:0]     sources,
  input  logic                   mask_wr,
  input  logic [SOURCES-1:0]     mask_data,
  input  logic                   irq_ack,
  input  logic                   irq_done,
  output logic                   irq,
  output logic [VECTOR_BITS-1:0] irq_vector,
  output logic [SOURCES-1:0]     pending,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [SOURCES-1:0]     src_prev;
  logic [SOURCES-1:0]     mask, mask_n;
  logic [SOURCES-1:0]     pending_n;
  logic [SOURCES-1:0]     src_edge;
  logic [SOURCES-1:0]     active;
  logic [SOURCES-1:0]     accept_clr;
  logic [VECTOR_BITS-1:0] winner;
  logic [VECTOR_BITS-1:0] irq_vector_n;
  logic                   irq_n;
  logic                   busy_n;

  assign src_edge = sources & ~src_prev;
  assign active   = pending & mask;

  // Lowest active index wins; scan from the top so the last hit is the lowest.
  always_comb begin
    winner = '0;
    for (int i = int'(SOURCES) - 1; i >= 0; i--) begin
      if (active[i]) winner = VECTOR_BITS'(i);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n      = state;
    irq_n        = irq;
    irq_vector_n = irq_vector;
    busy_n       = busy;
    accept_clr   = '0;
    mask_n       = mask_wr ? mask_data : mask;

    case (state)
      IDLE: begin
        irq_n  = 1'b0;
        busy_n = 1'b0;
        if (|active) begin
          irq_vector_n = winner;
          irq_n        = 1'b1;
          state_n      = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          for (int i = 0; i < int'(SOURCES); i++) begin
            accept_clr[i] = (VECTOR_BITS'(i) == irq_vector);
          end
          irq_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = SERVICE;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        irq_n   = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase

    // A new edge beats an acceptance clear of the same bit.
    pending_n = (pending & ~accept_clr) | src_edge;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      src_prev   <= '0;
      pending    <= '0;
      mask       <= '0;
      irq        <= 1'b0;
      irq_vector <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      src_prev   <= sources;
      pending    <= pending_n;
      mask       <= mask_n;
      irq        <= irq_n;
      irq_vector <= irq_vector_n;
      busy       <= busy_n;
    end
  end

endmodule
